irq_priority_arbiter: RTL and testbench
=======================================

// Module: irq_priority_arbiter
// PURPOSE
//  Prioritising arbiter and sequencer for the interrupt path. Captures N_IRQ edge-triggered
//  sources into pending bits and selects one winner per arbitration round by programmable
//  priority and threshold. Drives a single CPU interrupt line with an ack/EOI handshake.
//  Sits between peripheral IRQ lines and the core; configured over APB.
// PARAMETERS
//  N_IRQ    4  number of interrupt sources (2..16)
//  PRIO_W   3  priority field width; priority 0 = never selected
//  ID_W     2  width of irq_id_o, $clog2(N_IRQ)
// PORTS
//  pclk_i      in   1      clock, all logic on rising edge
//  rst_n_i     in   1      asynchronous active-low reset
//  psel_i      in   1      APB select
//  penable_i   in   1      APB enable
//  pwrite_i    in   1      APB write
//  paddr_i     in   32     APB byte address; bits [7:0] decoded
//  pwdata_i    in   32     APB write data
//  prdata_o    out  32     APB read data
//  pready_o    out  1      tied 1, zero wait states
//  pslverr_o   out  1      1 during access phase to unmapped address
//  irq_src_i   in   N_IRQ  source lines, synchronous to pclk_i, rising edge = request
//  irq_o       out  1      interrupt to CPU
//  irq_id_o    out  ID_W   id of asserted/in-service source
//  irq_ack_i   in   1      CPU acknowledge, 1-cycle pulse
//  irq_eoi_i   in   1      CPU end-of-interrupt, 1-cycle pulse
// BEHAVIOUR
//  Reset: prdata_o=0, pslverr_o=0, irq_o=0, irq_id_o=0, pending=0, enable=0, threshold=0,
//   all priorities=0, FSM=IDLE.
//  Register map (write when psel&penable&pwrite; read data combinational on psel&~pwrite):
//   0x00 ENABLE  [N_IRQ-1:0] RW;  0x04 PENDING RO, write-1-to-clear;
//   0x08 THRESH  [PRIO_W-1:0] RW; 0x0C STATUS RO {in_service,irq_id_o,fsm_state[1:0]};
//   0x10+4*i PRIO[i] [PRIO_W-1:0] RW. Other addresses: read 0, writes ignored, pslverr_o=1.
//  Capture: irq_src_i registered once; pending[i] set on 0->1. Set beats same-cycle clear
//   (W1C or ack clear). Pending captured regardless of ENABLE.
//  Eligible i: pending & enable & PRIO[i] > THRESH. Winner = max PRIO, ties -> lowest index.
//  FSM: IDLE  -> ARB when any eligible.
//       ARB   (1 cycle) latch winner into irq_id_o; re-check eligibility: none -> IDLE,
//             else -> ASSERT with irq_o=1 next cycle (2 cycles eligible->irq_o).
//       ASSERT irq_o=1 until irq_ack_i; on ack: irq_o=0, pending[irq_id_o] cleared, -> SERVICE.
//       SERVICE wait irq_eoi_i -> IDLE; re-arbitration starts the cycle after EOI.
//  No nesting/preemption: higher-priority arrivals stay pending until EOI.
//  Config writes (ENABLE/THRESH/PRIO) in ASSERT/SERVICE do not retract the committed id.
//  W1C of the asserted source's pending bit in ASSERT: irq_o stays, ack still completes.
//  ack outside ASSERT and eoi outside SERVICE ignored; ack and eoi same cycle in ASSERT:
//   only ack honoured.
//  Reset asserted mid-operation: immediate return to reset values, in-flight irq lost.
// CONFIGURATION
//  IRQ_ROUND_ROBIN_EN defined: ties among equal max priority resolved round-robin, search
//   starting at (last granted id + 1) mod N_IRQ; pointer resets to N_IRQ-1 (first grant
//   favours id 0), advances on ack. Undefined: fixed lowest-index tie-break, no pointer.
// STRUCTURE
//  Package irq_arb_pkg: register offset constants, FSM state enum (IDLE,ARB,ASSERT,SERVICE
//   encoded 2'd0..2'd3), default widths.
//  Sub-module irq_prio_select: combinational max-priority/tie-break tree producing winner
//   id and valid from eligible vector, priorities and rr pointer. Top holds APB regs + FSM.
// TESTING
//  1 PRIO={1,3,2,3}, ENABLE=0xF, THRESH=0, edges on src 0..3 same cycle -> irq_o 2 cycles
//    later, irq_id_o=1; ack -> PENDING=0xD; eoi -> next irq_id_o=3, then 2, then 0.
//  2 THRESH=2, PRIO[0]=2, edge src0 -> no irq_o; write THRESH=1 -> irq_o, irq_id_o=0.
//  3 src2 level held high after ack -> no re-pend; drop and re-raise -> PENDING[2]=1.
//  4 In SERVICE for id1, edge on higher-priority src3 -> irq_o stays 0 until eoi, then id 3.
//  5 Read 0x40 -> prdata_o=0, pslverr_o=1; W1C 0x04 with 0x1 same cycle as src0 edge
//    -> PENDING[0]=1.
//  6 rst_n_i low during ASSERT -> irq_o=0, PENDING=0, STATUS=0 immediately; with
//    IRQ_ROUND_ROBIN_EN, equal PRIO on 0..3 all pending -> grant order 0,1,2,3.

Source files
------------

// File: rtl/irq_arb_pkg.sv
// Shared constants and types for the interrupt priority arbiter.
// Register offsets, FSM state encoding and default widths.
package irq_arb_pkg;

    localparam int N_IRQ_DEF  = 4;
    localparam int PRIO_W_DEF = 3;
    localparam int ID_W_DEF   = 2;

    localparam logic [7:0] OFF_ENABLE  = 8'h00;
    localparam logic [7:0] OFF_PENDING = 8'h04;
    localparam logic [7:0] OFF_THRESH  = 8'h08;
    localparam logic [7:0] OFF_STATUS  = 8'h0C;
    localparam logic [7:0] OFF_PRIO    = 8'h10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARB     = 2'd1,
        ASSERT  = 2'd2,
        SERVICE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/irq_arb_if.sv
// APB slave port plus interrupt source/CPU handshake lines.
// slave = arbiter side, master = bus/CPU/peripheral side.
interface irq_arb_if #(
    parameter int N_IRQ = 4,
    parameter int ID_W  = 2
);
    logic             psel_i;
    logic             penable_i;
    logic             pwrite_i;
    logic [31:0]      paddr_i;
    logic [31:0]      pwdata_i;
    logic [31:0]      prdata_o;
    logic             pready_o;
    logic             pslverr_o;
    logic [N_IRQ-1:0] irq_src_i;
    logic             irq_o;
    logic [ID_W-1:0]  irq_id_o;
    logic             irq_ack_i;
    logic             irq_eoi_i;

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        input  irq_src_i, irq_ack_i, irq_eoi_i,
        output prdata_o, pready_o, pslverr_o, irq_o, irq_id_o
    );

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        output irq_src_i, irq_ack_i, irq_eoi_i,
        input  prdata_o, pready_o, pslverr_o, irq_o, irq_id_o
    );
endinterface

// File: rtl/irq_prio_select.sv
// Max-priority winner select; ties go to the first eligible id
// at or after (rr_ptr + 1) mod N_IRQ.
module irq_prio_select #(
    parameter int N_IRQ  = 4,
    parameter int PRIO_W = 3,
    parameter int ID_W   = 2
) (
    input  logic [N_IRQ-1:0]             elig,
    input  logic [N_IRQ-1:0][PRIO_W-1:0] prio,
    input  logic [ID_W-1:0]              rr_ptr,
    output logic [ID_W-1:0]              win_id,
    output logic                         win_vld
);

    logic [PRIO_W-1:0] max_p;

    always_comb begin
        max_p = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (elig[i] && prio[i] > max_p) max_p = prio[i];
        end
    end

    always_comb begin
        int   start;
        int   idx;
        logic found;
        start  = (int'(rr_ptr) + 1) % N_IRQ;
        idx    = 0;
        found  = 1'b0;
        win_id = '0;
        for (int k = 0; k < N_IRQ; k++) begin
            idx = start + k;
            if (idx >= N_IRQ) idx = idx - N_IRQ;
            if (!found && elig[idx] && prio[idx] == max_p) begin
                found  = 1'b1;
                win_id = ID_W'(idx);
            end
        end
    end

    assign win_vld = |elig;

endmodule

// File: rtl/irq_priority_arbiter.sv
// Interrupt priority arbiter: APB registers, edge capture and CPU handshake FSM.
// Define IRQ_ROUND_ROBIN_EN for round-robin tie-break among equal priorities.
module irq_priority_arbiter
    import irq_arb_pkg::*;
#(
    parameter int N_IRQ  = N_IRQ_DEF,
    parameter int PRIO_W = PRIO_W_DEF,
    parameter int ID_W   = ID_W_DEF
) (
    input logic      pclk_i,
    input logic      rst_n_i,
    irq_arb_if.slave bus
);

    logic [N_IRQ-1:0]             src_q;
    logic [N_IRQ-1:0]             pend_q;
    logic [N_IRQ-1:0]             pend_d;
    logic [N_IRQ-1:0]             en_q;
    logic [PRIO_W-1:0]            thr_q;
    logic [N_IRQ-1:0][PRIO_W-1:0] prio_q;
    logic [ID_W-1:0]              id_q;
    logic [ID_W-1:0]              rr_ptr;
    logic [ID_W-1:0]              win_id;
    logic                         win_vld;
    arb_state_e                   st_q;
    arb_state_e                   st_d;

    logic [7:0]       addr;
    logic             wr_en;
    logic             rd_en;
    logic             mapped;
    logic [N_IRQ-1:0] prio_sel;
    logic [31:0]      rdata;
    logic [N_IRQ-1:0] elig;
    logic [N_IRQ-1:0] w1c;
    logic [N_IRQ-1:0] ack_clr;
    logic             ack_fire;
    logic             unused;

    assign addr  = bus.paddr_i[7:0];
    assign wr_en = bus.psel_i & bus.penable_i & bus.pwrite_i;
    assign rd_en = bus.psel_i & ~bus.pwrite_i;

    always_comb begin
        prio_sel = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            prio_sel[i] = (addr == OFF_PRIO + 8'(4 * i));
        end
    end

    assign mapped = (addr == OFF_ENABLE) | (addr == OFF_PENDING)
                  | (addr == OFF_THRESH) | (addr == OFF_STATUS)
                  | (|prio_sel);

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            addr == OFF_ENABLE:  rdata = 32'(en_q);
            addr == OFF_PENDING: rdata = 32'(pend_q);
            addr == OFF_THRESH:  rdata = 32'(thr_q);
            addr == OFF_STATUS:
                rdata = 32'({st_q == SERVICE, id_q, st_q});
            |prio_sel: begin
                for (int i = 0; i < N_IRQ; i++) begin
                    if (prio_sel[i]) rdata = 32'(prio_q[i]);
                end
            end
            default: rdata = '0;
        endcase
    end

    assign bus.prdata_o  = rd_en ? rdata : '0;
    assign bus.pready_o  = 1'b1;
    assign bus.pslverr_o = bus.psel_i & bus.penable_i & ~mapped;

    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            en_q   <= '0;
            thr_q  <= '0;
            prio_q <= '0;
        end else if (wr_en) begin
            if (addr == OFF_ENABLE) en_q <= bus.pwdata_i[N_IRQ-1:0];
            if (addr == OFF_THRESH) thr_q <= bus.pwdata_i[PRIO_W-1:0];
            for (int i = 0; i < N_IRQ; i++) begin
                if (prio_sel[i]) prio_q[i] <= bus.pwdata_i[PRIO_W-1:0];
            end
        end
    end

    // New edges win over W1C and ack clears landing in the same cycle.
    assign ack_fire = (st_q == ASSERT) & bus.irq_ack_i;
    assign ack_clr  = ack_fire ? (N_IRQ'(1) << id_q) : '0;
    assign w1c      = (wr_en && addr == OFF_PENDING)
                    ? bus.pwdata_i[N_IRQ-1:0] : '0;
    assign pend_d   = (pend_q & ~w1c & ~ack_clr)
                    | (bus.irq_src_i & ~src_q);

    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            src_q  <= '0;
            pend_q <= '0;
        end else begin
            src_q  <= bus.irq_src_i;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        for (int i = 0; i < N_IRQ; i++) begin
            elig[i] = pend_q[i] & en_q[i] & (prio_q[i] > thr_q);
        end
    end

`ifdef IRQ_ROUND_ROBIN_EN
    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i)      rr_ptr <= ID_W'(N_IRQ - 1);
        else if (ack_fire) rr_ptr <= id_q;
    end
`else
    assign rr_ptr = ID_W'(N_IRQ - 1);
`endif

    irq_prio_select #(
        .N_IRQ  (N_IRQ),
        .PRIO_W (PRIO_W),
        .ID_W   (ID_W)
    ) u_sel (
        .elig    (elig),
        .prio    (prio_q),
        .rr_ptr  (rr_ptr),
        .win_id  (win_id),
        .win_vld (win_vld)
    );

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            IDLE:    if (|elig) st_d = ARB;
            ARB:     st_d = win_vld ? ASSERT : IDLE;
            ASSERT:  if (bus.irq_ack_i) st_d = SERVICE;
            SERVICE: if (bus.irq_eoi_i) st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            st_q <= IDLE;
            id_q <= '0;
        end else begin
            st_q <= st_d;
            if (st_q == ARB && win_vld) id_q <= win_id;
        end
    end

    assign bus.irq_o    = (st_q == ASSERT);
    assign bus.irq_id_o = id_q;

    assign unused = ^{bus.paddr_i[31:8], bus.pwdata_i};

endmodule

// File: tb/tb_irq_priority_arbiter.sv
// Directed and randomized bench for irq_priority_arbiter.
// Reference model: pending set plus priority rules evaluated per grant.
module tb_irq_priority_arbiter;

    localparam int N = 4;
`ifdef IRQ_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic pclk_i  = 1'b0;
    logic rst_n_i = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    bit [N-1:0] m_pend;
    bit [N-1:0] m_en;
    int         m_prio [N];
    int         m_thr;
    int         m_last;

    always #5 pclk_i = ~pclk_i;

    irq_arb_if #(.N_IRQ(N), .ID_W(2)) bus ();

    irq_priority_arbiter #(
        .N_IRQ  (N),
        .PRIO_W (3),
        .ID_W   (2)
    ) dut (
        .pclk_i  (pclk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk_i);
        #1;
    endtask

    task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
        bus.psel_i    = 1'b1;
        bus.pwrite_i  = 1'b1;
        bus.penable_i = 1'b0;
        bus.paddr_i   = {24'h0, a};
        bus.pwdata_i  = d;
        tick();
        bus.penable_i = 1'b1;
        tick();
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = 1'b0;
        if (a == 8'h00) m_en = d[N-1:0];
        if (a == 8'h04) m_pend = m_pend & ~d[N-1:0];
        if (a == 8'h08) m_thr = int'(d[2:0]);
        if (a >= 8'h10 && a < 8'h20) m_prio[(a - 8'h10) / 4] = int'(d[2:0]);
    endtask

    task automatic apb_rd(input logic [7:0] a, output logic [31:0] d,
                          output logic e);
        bus.psel_i    = 1'b1;
        bus.pwrite_i  = 1'b0;
        bus.penable_i = 1'b0;
        bus.paddr_i   = {24'h0, a};
        tick();
        bus.penable_i = 1'b1;
        #1;
        d = bus.prdata_o;
        e = bus.pslverr_o;
        tick();
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
    endtask

    task automatic pulse(input logic [N-1:0] m);
        bus.irq_src_i = m;
        m_pend        = m_pend | m;
        tick();
        bus.irq_src_i = '0;
    endtask

    task automatic wait_irq(input string tag);
        int n = 0;
        while (bus.irq_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.irq_o), 32'd1);
    endtask

    task automatic ack();
        m_pend[bus.irq_id_o] = 1'b0;
        m_last = int'(bus.irq_id_o);
        bus.irq_ack_i = 1'b1;
        tick();
        bus.irq_ack_i = 1'b0;
    endtask

    task automatic eoi();
        bus.irq_eoi_i = 1'b1;
        tick();
        bus.irq_eoi_i = 1'b0;
    endtask

    task automatic model_reset();
        m_pend = '0;
        m_en   = '0;
        m_thr  = 0;
        m_last = N - 1;
        for (int i = 0; i < N; i++) m_prio[i] = 0;
    endtask

    function automatic int m_win();
        int best = -1;
        int bp   = 0;
        for (int k = 0; k < N; k++) begin
            int i;
            i = RR ? (m_last + 1 + k) % N : k;
            if (m_pend[i] && m_en[i] && m_prio[i] > m_thr && m_prio[i] > bp) begin
                best = i;
                bp   = m_prio[i];
            end
        end
        return best;
    endfunction

    initial begin
        logic [31:0] rd;
        logic        er;
        int          w;
        int          order [4];

        bus.psel_i = 0; bus.penable_i = 0; bus.pwrite_i = 0;
        bus.paddr_i = 0; bus.pwdata_i = 0; bus.irq_src_i = 0;
        bus.irq_ack_i = 0; bus.irq_eoi_i = 0;
        model_reset();
        repeat (3) tick();
        rst_n_i = 1'b1;
        tick();

        chk("rst_irq", 32'(bus.irq_o), 0);
        chk("rst_id", 32'(bus.irq_id_o), 0);
        chk("rst_pready", 32'(bus.pready_o), 1);
        apb_rd(8'h04, rd, er);
        chk("rst_pend", rd, 0);
        apb_rd(8'h0C, rd, er);
        chk("rst_status", rd, 0);

        // Test 1: mixed priorities, all four edges together
        apb_wr(8'h10, 1); apb_wr(8'h14, 3); apb_wr(8'h18, 2); apb_wr(8'h1C, 3);
        apb_wr(8'h00, 32'hF); apb_wr(8'h08, 0);
        pulse(4'hF);
        tick();
        chk("t1_lat_lo", 32'(bus.irq_o), 0);
        tick();
        chk("t1_lat_hi", 32'(bus.irq_o), 1);
        chk("t1_id1", 32'(bus.irq_id_o), 1);
        ack();
        chk("t1_drop", 32'(bus.irq_o), 0);
        apb_rd(8'h04, rd, er);
        chk("t1_pend", rd, 32'hD);
        apb_rd(8'h0C, rd, er);
        chk("t1_status", rd, 32'h17);
        eoi();
        wait_irq("t1_irq3");
        chk("t1_id3", 32'(bus.irq_id_o), 3);
        ack(); eoi();
        wait_irq("t1_irq2");
        chk("t1_id2", 32'(bus.irq_id_o), 2);
        ack(); eoi();
        wait_irq("t1_irq0");
        chk("t1_id0", 32'(bus.irq_id_o), 0);
        ack(); eoi();

        // Test 2: threshold gating
        apb_wr(8'h08, 2); apb_wr(8'h10, 2);
        pulse(4'h1);
        repeat (4) tick();
        chk("t2_gated", 32'(bus.irq_o), 0);
        apb_wr(8'h08, 1);
        wait_irq("t2_irq");
        chk("t2_id", 32'(bus.irq_id_o), 0);
        ack(); eoi();

        // Test 3: level held high does not re-pend; ack+eoi together
        bus.irq_src_i = 4'h4;
        tick();
        wait_irq("t3_irq");
        chk("t3_id", 32'(bus.irq_id_o), 2);
        bus.irq_ack_i = 1'b1; bus.irq_eoi_i = 1'b1;
        tick();
        bus.irq_ack_i = 1'b0; bus.irq_eoi_i = 1'b0;
        apb_rd(8'h0C, rd, er);
        chk("t3_ack_only", rd, 32'h1B);
        eoi();
        repeat (3) tick();
        apb_rd(8'h04, rd, er);
        chk("t3_no_repend", rd, 0);
        chk("t3_quiet", 32'(bus.irq_o), 0);
        bus.irq_src_i = 4'h0; tick();
        bus.irq_src_i = 4'h4; tick();
        apb_rd(8'h04, rd, er);
        chk("t3_repend", rd, 32'h4);
        wait_irq("t3_irq2");
        ack(); eoi();
        bus.irq_src_i = 4'h0;
        tick();

        // Test 4: no preemption; config write during ASSERT
        pulse(4'h2);
        wait_irq("t4_irq1");
        chk("t4_id1", 32'(bus.irq_id_o), 1);
        ack();
        pulse(4'h8);
        repeat (5) tick();
        chk("t4_no_preempt", 32'(bus.irq_o), 0);
        eoi();
        wait_irq("t4_irq3");
        chk("t4_id3", 32'(bus.irq_id_o), 3);
        apb_wr(8'h00, 0);
        chk("t4_hold_irq", 32'(bus.irq_o), 1);
        chk("t4_hold_id", 32'(bus.irq_id_o), 3);
        ack(); eoi();
        apb_wr(8'h00, 32'hF);

        // Test 5: unmapped access, set beats W1C
        apb_rd(8'h40, rd, er);
        chk("t5_unmap_rd", rd, 0);
        chk("t5_unmap_err", 32'(er), 1);
        apb_rd(8'h14, rd, er);
        chk("t5_prio_rd", rd, 3);
        chk("t5_map_err", 32'(er), 0);
        apb_wr(8'h00, 0);
        pulse(4'h1);
        tick();
        bus.psel_i = 1; bus.pwrite_i = 1; bus.penable_i = 0;
        bus.paddr_i = 32'h4; bus.pwdata_i = 32'h1;
        tick();
        bus.penable_i = 1; bus.irq_src_i = 4'h1;
        tick();
        bus.psel_i = 0; bus.penable_i = 0; bus.pwrite_i = 0;
        bus.irq_src_i = 4'h0;
        apb_rd(8'h04, rd, er);
        chk("t5_set_wins", rd, 32'h1);
        apb_wr(8'h04, 32'h1);
        apb_rd(8'h04, rd, er);
        chk("t5_w1c", rd, 0);

        // W1C of asserted source, stray eoi in ASSERT
        apb_wr(8'h00, 32'hF);
        pulse(4'h1);
        wait_irq("t5_irq0");
        apb_wr(8'h04, 32'h1);
        eoi();
        chk("t5_w1c_hold", 32'(bus.irq_o), 1);
        chk("t5_w1c_id", 32'(bus.irq_id_o), 0);
        ack();
        chk("t5_w1c_ack", 32'(bus.irq_o), 0);
        eoi();

        // Test 6: async reset during ASSERT
        pulse(4'h1);
        wait_irq("t6_irq");
        rst_n_i = 1'b0;
        #1;
        chk("t6_rst_irq", 32'(bus.irq_o), 0);
        bus.psel_i = 1; bus.pwrite_i = 0; bus.paddr_i = 32'h4;
        #1;
        chk("t6_rst_pend", bus.prdata_o, 0);
        bus.paddr_i = 32'hC;
        #1;
        chk("t6_rst_status", bus.prdata_o, 0);
        bus.psel_i = 0;
        model_reset();
        repeat (2) tick();
        rst_n_i = 1'b1;
        tick();

        // Equal priorities: grant order 0,1,2,3 from reset
        for (int i = 0; i < N; i++) apb_wr(8'(8'h10 + 4 * i), 2);
        apb_wr(8'h00, 32'hF);
        pulse(4'hF);
        for (int g = 0; g < N; g++) begin
            wait_irq("t6_eq_irq");
            order[g] = int'(bus.irq_id_o);
            ack(); eoi();
        end
        for (int g = 0; g < N; g++) chk("t6_eq_order", 32'(order[g]), 32'(g));

        // Randomized rounds against the reference model
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < N; i++)
                apb_wr(8'(8'h10 + 4 * i), $urandom_range(0, 7));
            apb_wr(8'h00, $urandom_range(0, 15));
            apb_wr(8'h08, $urandom_range(0, 3));
            pulse(4'($urandom_range(1, 15)));
            for (int g = 0; g <= N; g++) begin
                w = m_win();
                if (w < 0) begin
                    repeat (4) tick();
                    chk("rnd_idle", 32'(bus.irq_o), 0);
                    break;
                end
                wait_irq("rnd_irq");
                chk("rnd_id", 32'(bus.irq_id_o), 32'(w));
                ack(); eoi();
            end
            apb_rd(8'h04, rd, er);
            chk("rnd_pend", rd, 32'(m_pend));
            apb_wr(8'h04, 32'hF);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
